// File: rtl/rom_arb_pkg.sv
// Shared definitions for the two-requester ROM read arbiter:
// FSM state encoding, requester count and a small one-hot helper.
package rom_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        READ = 2'b01,
        RESP = 2'b10
    } state_e;

    // Convert a requester index into its one-hot response/grant vector.
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic idx);
        logic [NUM_REQ-1:0] oh;
        if (idx) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

endpackage

// File: rtl/rom_rr_arbiter.sv
// Two-way grant selection. A lone requester always wins; on a tie the
// requester that was NOT granted last wins. Tying last_grant high turns
// this into fixed priority with requester 0 first.
module rom_rr_arbiter
    import rom_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] grant
);

    // One-hot grant from the current requests and the last-grant index.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates two read requesters onto one synchronous-read ROM.
// Flow per read: IDLE (accept) -> READ (ROM latency) -> RESP (hold until
// the owner takes the word). One read per three cycles at best.
// Build option: define ROM_ARB_RR_EN for round-robin arbitration; without
// it requester 0 has fixed priority and no last-grant state exists.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter  int Width = 16,
    parameter  int Depth = 1024,
    localparam int AW    = $clog2(Depth)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [Width-1:0]      rsp_data,
    output logic [AW-1:0]         rom_addr,
    input  logic [Width-1:0]      rom_data
);

    // Addresses at or above this limit only exist when Depth is not a power
    // of two; they are still presented to the ROM but their data is zeroed.
    localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(Depth);

    state_e            state_q, state_d;
    logic [AW-1:0]     rom_addr_q, rom_addr_d;
    logic              owner_q, owner_d;
    logic              oob_q, oob_d;
    logic              last_grant_s;
    logic [NUM_REQ-1:0] grant_s;
    logic              sel_s;
    logic [AW-1:0]     sel_addr_s;
    logic              accept_s;

`ifdef ROM_ARB_RR_EN
    logic              last_q, last_d;
    assign last_grant_s = last_q;
`else
    // Pretending requester 1 always went last makes ties go to requester 0.
    assign last_grant_s = 1'b1;
`endif

    rom_rr_arbiter u_arb (
        .valid      (req_valid),
        .last_grant (last_grant_s),
        .grant      (grant_s)
    );

    assign sel_s      = grant_s[1];
    assign sel_addr_s = sel_s ? req_addr[AW +: AW] : req_addr[0 +: AW];
    assign accept_s   = (state_q == IDLE) && (grant_s != 2'b00);
    assign rom_addr   = rom_addr_q;

    // Next-state and captured-transaction logic for the read sequence.
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        owner_d    = owner_q;
        oob_d      = oob_q;
`ifdef ROM_ARB_RR_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d    = READ;
                    rom_addr_d = sel_addr_s;
                    owner_d    = sel_s;
                    oob_d      = ({1'b0, sel_addr_s} >= DEPTH_LIM);
`ifdef ROM_ARB_RR_EN
                    last_d     = sel_s;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs: ready only while idle and out of reset, response
    // only in RESP, with out-of-range reads returning zero.
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        rsp_data  = {Width{1'b0}};
        if ((state_q == IDLE) && rst_n) begin
            req_ready = grant_s;
        end else begin
            req_ready = 2'b00;
        end
        if (state_q == RESP) begin
            rsp_valid = idx_to_onehot(owner_q);
            rsp_data  = oob_q ? {Width{1'b0}} : rom_data;
        end else begin
            rsp_valid = 2'b00;
            rsp_data  = {Width{1'b0}};
        end
    end

    // Transaction state registers; reset aborts any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rom_addr_q <= {AW{1'b0}};
            owner_q    <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            owner_q    <= owner_d;
            oob_q      <= oob_d;
        end
    end

`ifdef ROM_ARB_RR_EN
    // Last-grant pointer; resets to requester 1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: a table of single transactions
// with a response scoreboard, plus hand-written reset and
// non-power-of-two depth sequences. Honours ROM_ARB_RR_EN.
module tb_rom_arbiter;

    localparam int W  = 16;
    localparam int AW = 10;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
    logic [2*AW-1:0] req_addr;
    logic [W-1:0]    rsp_data, rom_data;
    logic [AW-1:0]   rom_addr;

    logic [1:0]      b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [2*AW-1:0] b_req_addr;
    logic [W-1:0]    b_rsp_data, b_rom_data;
    logic [AW-1:0]   b_rom_addr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]    valid;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [1:0]    gnt;
        int            stall;
        logic [1:0]    nxt;
    } vec_t;

    typedef struct {
        logic [1:0]   owner;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];

    always #5 clk = ~clk;

    rom_arbiter #(.Width(W), .Depth(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rom_addr(rom_addr), .rom_data(rom_data)
    );

    rom_arbiter #(.Width(W), .Depth(1000)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
        .rom_addr(b_rom_addr), .rom_data(b_rom_data)
    );

    function automatic logic [W-1:0] rom_word(input logic [AW-1:0] a);
        return {a[5:0], a} ^ 16'h5A3C;
    endfunction

    // Synchronous-read ROM models (contents defined for every address).
    always @(posedge clk) begin
        rom_data   <= rom_word(rom_addr);
        b_rom_data <= rom_word(b_rom_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one request set starting just after a rising edge in IDLE.
    task automatic run_txn(input vec_t v);
        logic [AW-1:0] ga;
        logic [AW-1:0] a_hold;
        logic [W-1:0]  d_hold;
        exp_t          e;
        exp_t          got;
        got = '{2'b00, 16'h0000};
        req_valid = v.valid;
        req_addr  = {v.a1, v.a0};
        @(negedge clk);
        chk("idle_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("grant_ready", {30'd0, req_ready}, {30'd0, v.gnt});
        ga      = v.gnt[1] ? v.a1 : v.a0;
        e.owner = v.gnt;
        e.data  = rom_word(ga);
        sb.push_back(e);
        @(posedge clk); #1;
        chk("read_rom_addr", {22'd0, rom_addr}, {22'd0, ga});
        chk("read_req_ready", {30'd0, req_ready}, 32'd0);
        chk("read_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        req_valid = v.nxt;
        @(negedge clk);
        chk("resp_latency", {30'd0, rsp_valid}, {30'd0, v.gnt});
        d_hold    = rsp_data;
        a_hold    = rom_addr;
        rsp_ready = ~v.gnt;
        for (int i = 0; i < v.stall; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", {30'd0, rsp_valid}, {30'd0, v.gnt});
            chk("stall_rsp_data", {16'd0, rsp_data}, {16'd0, d_hold});
            chk("stall_rom_addr", {22'd0, rom_addr}, {22'd0, a_hold});
            chk("stall_req_ready", {30'd0, req_ready}, 32'd0);
        end
        rsp_ready = v.gnt;
        chk("resp_req_ready", {30'd0, req_ready}, 32'd0);
        if (sb.size() > 0) got = sb.pop_front();
        chk("sb_owner", {30'd0, rsp_valid}, {30'd0, got.owner});
        chk("sb_data", {16'd0, rsp_data}, {16'd0, got.data});
        @(posedge clk); #1;
        rsp_ready = 2'b00;
    endtask

    // Single read on the Depth=1000 instance.
    task automatic b_read(input logic [AW-1:0] a, input logic [W-1:0] exp, input string nm);
        b_req_valid = 2'b01;
        b_req_addr  = {10'd0, a};
        @(negedge clk);
        chk("b_ready", {30'd0, b_req_ready}, 32'd1);
        @(posedge clk); #1;
        b_req_valid = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        chk("b_rsp_valid", {30'd0, b_rsp_valid}, 32'd1);
        chk(nm, {16'd0, b_rsp_data}, {16'd0, exp});
        b_rsp_ready = 2'b01;
        @(posedge clk); #1;
        b_rsp_ready = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] g_alt;
        int         bad;
`ifdef ROM_ARB_RR_EN
        g_alt = 2'b10;
`else
        g_alt = 2'b01;
`endif
        vecs[0] = '{2'b01, 10'd5,   10'd0,  2'b01, 0, 2'b00};
        vecs[1] = '{2'b10, 10'd0,   10'd7,  2'b10, 0, 2'b00};
        vecs[2] = '{2'b01, 10'd1023, 10'd0, 2'b01, 0, 2'b00};
        vecs[3] = '{2'b10, 10'd0,   10'd0,  2'b10, 5, 2'b00};
        vecs[4] = '{2'b11, 10'd21,  10'd22, 2'b01, 0, 2'b11};
        vecs[5] = '{2'b11, 10'd23,  10'd24, g_alt, 0, 2'b11};
        vecs[6] = '{2'b11, 10'd25,  10'd26, 2'b01, 0, 2'b11};
        vecs[7] = '{2'b11, 10'd27,  10'd28, g_alt, 0, 2'b00};
        vecs[8] = '{2'b01, 10'd11,  10'd12, 2'b01, 2, 2'b10};
        vecs[9] = '{2'b10, 10'd11,  10'd12, 2'b10, 0, 2'b00};

        req_valid = 2'b01;
        req_addr = '0;
        rsp_ready = 2'b00;
        b_req_valid = 2'b00;
        b_req_addr = '0;
        b_rsp_ready = 2'b00;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_rom_addr", {22'd0, rom_addr}, 32'd0);
        repeat (2) @(negedge clk);
        req_valid = 2'b00;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 10; k++) run_txn(vecs[k]);
        req_valid = 2'b00;

        // Reset pulsed during READ aborts the read.
        req_valid = 2'b01;
        req_addr  = {10'd0, 10'd9};
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("midrst_rom_addr", {22'd0, rom_addr}, 32'd0);
        chk("midrst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("midrst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("midrst_rsp_data", {16'd0, rsp_data}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid !== 2'b00) bad++;
        end
        chk("no_rsp_after_rst", bad, 32'd0);
        @(posedge clk); #1;
        run_txn('{2'b11, 10'd3, 10'd4, 2'b01, 0, 2'b00});

        b_read(10'd999, rom_word(10'd999), "b_last_in_range");
        b_read(10'd1010, 16'h0000, "b_oob_zero");

        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter Width, default 16, meaning ROM word width in bits.
REQ-002 SHALL have parameter Depth, default 1024, meaning ROM entry count; AW = $clog2(Depth).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  2  per-requester read request.
REQ-006 SHALL have port req_ready  output  2  per-requester accept, at most one bit high.
REQ-007 SHALL have port req_addr  input  2*AW  requester i address in bits [i*AW +: AW].
REQ-008 SHALL have port rsp_valid  output  2  one-hot response valid to owning requester.
REQ-009 SHALL have port rsp_ready  input  2  per-requester response accept.
REQ-010 SHALL have port rsp_data  output  Width  response word, meaningful only while rsp_valid nonzero.
REQ-011 SHALL have port rom_addr  output  AW  registered address to the synchronous-read ROM.
REQ-012 SHALL have port rom_data  input  Width  ROM read data, valid one clock edge after rom_addr is presented.

Function
REQ-013 SHALL implement FSM states IDLE, READ, RESP.
REQ-014 In IDLE with any req_valid high, SHALL drive req_ready high for the granted requester only, combinationally in the same cycle.
REQ-015 On the edge where req_valid[g] and req_ready[g] are both high, SHALL load rom_addr from req_addr[g], record owner g, and enter READ.
REQ-016 READ SHALL last exactly one cycle, with rom_addr held, then enter RESP.
REQ-017 In RESP, SHALL assert rsp_valid[owner] and drive rsp_data = rom_data, with rom_addr held stable so the data remains stable.
REQ-018 In RESP, SHALL hold state until rsp_ready[owner] is high, then return to IDLE; rsp_ready of the non-owner SHALL be ignored.
REQ-019 Latency SHALL be 2 cycles from accept edge to rsp_valid high; peak throughput SHALL be 1 read per 3 cycles.
REQ-020 req_ready SHALL be all-zero in READ and RESP; requests arriving then SHALL wait, and a request withdrawn before acceptance SHALL be dropped without side effects.
REQ-021 With both req_valid high in IDLE, SHALL grant according to REQ-027/028.
REQ-022 When Depth is not a power of two, an accepted address >= Depth SHALL return rsp_data = 0.
REQ-023 Address Depth-1 SHALL be read normally, with no wrap or special case.

Reset
REQ-024 On rst_n low, SHALL asynchronously force state IDLE, rom_addr 0, owner 0, rsp_valid 0, req_ready 0, and last-grant pointer 1.
REQ-025 Reset asserted mid-transaction SHALL abort it; no response SHALL be delivered after rst_n releases.
REQ-026 First grant after reset SHALL favour requester 0.

Configuration
REQ-027 With ROM_ARB_RR_EN defined, SHALL arbitrate round-robin: on a tie, grant the requester other than the last granted, and update last-grant on each accept.
REQ-028 Without ROM_ARB_RR_EN, SHALL use fixed priority, requester 0 over 1; the last-grant pointer SHALL be absent.

Structure
REQ-029 Package rom_arb_pkg SHALL hold the FSM state enum (IDLE, READ, RESP) and the constant NUM_REQ = 2.
REQ-030 Grant selection SHALL live in sub-module rom_rr_arbiter (inputs: valid and last-grant; output: one-hot grant); the ROM SHALL be instantiated outside this block.

Verification
REQ-031 Bench SHALL cover: reset; req_valid=01, addr 5 -> req_ready=01 same cycle, rsp_valid=01 two cycles later, rsp_data=ROM[5].
REQ-032 Bench SHALL cover: req_valid=11 held for 4 transactions -> with RR grants 0,1,0,1; without RR grants 0,0,0,0.
REQ-033 Bench SHALL cover: rsp_ready low for 5 cycles in RESP -> rsp_valid, rsp_data, and rom_addr stable, req_ready=00 throughout.
REQ-034 Bench SHALL cover: rst_n pulsed low during READ -> all outputs 0 immediately; no rsp_valid after release until a new request.
REQ-035 Bench SHALL cover: addr Depth-1 (1023) -> rsp_data=ROM[1023]; with Depth=1000, addr 1010 -> rsp_data=0.
REQ-036 Bench SHALL cover: req_valid[1] raised during RESP of requester 0 -> granted only after return to IDLE, with no lost or duplicated response.
